// File: rtl/relu_pkg.sv
// Shared definitions for the ReLU backward (gradient gating) datapath.
package relu_pkg;

  localparam int DATA_W    = 9;
  localparam int DEPTH_DEF = 64;

  typedef logic signed [DATA_W-1:0] grad_t;

endpackage

// File: rtl/mask_fifo.sv
// 1-bit-wide synchronous FIFO holding ReLU pass/zero decisions between the
// forward and backward passes. The count register alone decides full/empty,
// so the pointers are free to wrap modulo DEPTH.
module mask_fifo
  import relu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        din,
  input  logic        pop,
  output logic        dout,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // Pointer and occupancy bookkeeping; flush wins over any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

  // Mask storage is data only: no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/relu_backward.sv
// Backward ReLU: records a pass mask per forward activation and uses it, in
// the same order, to gate the upstream gradient into dL/dx.
module relu_backward
  import relu_pkg::*;
#(
  parameter int DATA_W = relu_pkg::DATA_W,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fwd_valid,
  output logic                     fwd_ready,
  input  logic signed [DATA_W-1:0] fwd_in,
  input  logic                     grad_valid,
  output logic                     grad_ready,
  input  logic signed [DATA_W-1:0] grad_in,
  output logic                     grad_out_valid,
  input  logic                     grad_out_ready,
  output logic signed [DATA_W-1:0] grad_out,
  output logic [CW-1:0]            mask_count
);

  logic                     w_full;
  logic                     w_empty;
  logic                     w_mask;
  logic                     w_push;
  logic                     w_pop;
  logic                     r_out_vld_p0;
  logic signed [DATA_W-1:0] r_out_p0;

  // Zero passes the forward ReLU, so only the sign bit clears the mask.
  function automatic logic relu_mask(input logic signed [DATA_W-1:0] x);
    return ~x[DATA_W-1];
  endfunction

  // Gradient flows through unchanged where the activation passed, else 0.
  function automatic logic signed [DATA_W-1:0] gate(
    input logic m, input logic signed [DATA_W-1:0] g);
    return m ? g : '0;
  endfunction

  assign fwd_ready  = !w_full;
  assign grad_ready = !w_empty && (!r_out_vld_p0 || grad_out_ready);
  assign w_push     = fwd_valid && fwd_ready;
  assign w_pop      = grad_valid && grad_ready;

  mask_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (w_push),
    .din   (relu_mask(fwd_in)),
    .pop   (w_pop),
    .dout  (w_mask),
    .count (mask_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Stage p0: output register, loaded on a pop and held under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld_p0 <= 1'b0;
      r_out_p0     <= '0;
    end else if (flush) begin
      r_out_vld_p0 <= 1'b0;
    end else if (w_pop) begin
      r_out_vld_p0 <= 1'b1;
      r_out_p0     <= gate(w_mask, grad_in);
    end else if (grad_out_ready) begin
      r_out_vld_p0 <= 1'b0;
    end
  end

  assign grad_out_valid = r_out_vld_p0;
  assign grad_out       = r_out_p0;

endmodule

// File: tb/tb_relu_backward.sv
// Self-checking bench for relu_backward: a queue-based behavioural model is
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_relu_backward;

  localparam int DATA_W = 9;
  localparam int DEPTH  = 64;
  localparam int CW     = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              fwd_valid;
  logic              fwd_ready;
  logic [DATA_W-1:0] fwd_in;
  logic              grad_valid;
  logic              grad_ready;
  logic [DATA_W-1:0] grad_in;
  logic              grad_out_valid;
  logic              grad_out_ready;
  logic [DATA_W-1:0] grad_out;
  logic [CW-1:0]     mask_count;

  relu_backward #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fwd_valid      (fwd_valid),
    .fwd_ready      (fwd_ready),
    .fwd_in         (fwd_in),
    .grad_valid     (grad_valid),
    .grad_ready     (grad_ready),
    .grad_in        (grad_in),
    .grad_out_valid (grad_out_valid),
    .grad_out_ready (grad_out_ready),
    .grad_out       (grad_out),
    .mask_count     (mask_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  bit                m_q[$];
  bit                m_vld;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] obs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: check outputs mid-cycle, then advance the model one edge.
  always @(negedge clk) begin
    bit ef, er, pop, push, m;
    #1;
    if (rst) begin
      m_q.delete();
      m_vld  = 1'b0;
      m_data = '0;
    end else begin
      ef = (m_q.size() != DEPTH);
      er = (m_q.size() != 0) && (!m_vld || grad_out_ready);
      chk("fwd_ready", 32'(fwd_ready), 32'(ef));
      chk("grad_ready", 32'(grad_ready), 32'(er));
      chk("mask_count", 32'(mask_count), 32'(m_q.size()));
      chk("grad_out_valid", 32'(grad_out_valid), 32'(m_vld));
      if (m_vld) chk("grad_out", 32'(grad_out), 32'(m_data));
      if (grad_out_valid && grad_out_ready) obs.push_back(grad_out);
      if (flush) begin
        m_q.delete();
        m_vld = 1'b0;
      end else begin
        pop  = grad_valid && er;
        push = fwd_valid && ef;
        if (pop) begin
          m      = m_q.pop_front();
          m_vld  = 1'b1;
          m_data = m ? grad_in : '0;
        end else if (grad_out_ready) begin
          m_vld = 1'b0;
        end
        if (push) m_q.push_back(!fwd_in[DATA_W-1]);
      end
    end
  end

  task automatic cyc(input logic fv, input logic [DATA_W-1:0] fi, input logic gv,
                     input logic [DATA_W-1:0] gi, input logic gr, input logic fl);
    @(negedge clk);
    fwd_valid      = fv;
    fwd_in         = fi;
    grad_valid     = gv;
    grad_in        = gi;
    grad_out_ready = gr;
    flush          = fl;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  function automatic logic [DATA_W-1:0] pos_rand();
    logic [DATA_W-2:0] v;
    v = (DATA_W-1)'($urandom);
    return {1'b0, v};
  endfunction

  task automatic drain();
    for (int i = 0; i < 80 && mask_count != 0; i++)
      cyc(1'b0, '0, 1'b1, DATA_W'($urandom), 1'b1, 1'b0);
    idle();
    idle();
    #2 chk("drain_empty", 32'(mask_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; fwd_valid = 1'b0; fwd_in = '0;
    grad_valid = 1'b0; grad_in = '0; grad_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_fwd_ready", 32'(fwd_ready), 32'd1);
    chk("rst_grad_ready", 32'(grad_ready), 32'd0);
    chk("rst_out_valid", 32'(grad_out_valid), 32'd0);
    chk("rst_count", 32'(mask_count), 32'd0);
    chk("rst_grad_out", 32'(grad_out), 32'd0);

    // Ordering: masks 1,0,1 gate gradients 010,020,030
    obs.delete();
    cyc(1'b1, 9'h005, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 9'h1FB, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 9'h000, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 9'h010, 1'b1, 1'b0);
    #2 chk("ord_lat_not_yet", 32'(grad_out_valid), 32'd0);
    cyc(1'b0, '0, 1'b1, 9'h020, 1'b1, 1'b0);
    #2 chk("ord_lat_out0", 32'(grad_out), 32'h010);
    cyc(1'b0, '0, 1'b1, 9'h030, 1'b1, 1'b0);
    repeat (3) idle();
    chk("ord_n", 32'(obs.size()), 32'd3);
    if (obs.size() == 3) begin
      chk("ord_0", 32'(obs[0]), 32'h010);
      chk("ord_1", 32'(obs[1]), 32'h000);
      chk("ord_2", 32'(obs[2]), 32'h030);
    end

    // Full
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, pos_rand(), 1'b0, '0, 1'b1, 1'b0);
    idle();
    #2 chk("full_count", 32'(mask_count), 32'd64);
    chk("full_fwd_ready", 32'(fwd_ready), 32'd0);
    cyc(1'b1, pos_rand(), 1'b0, '0, 1'b1, 1'b0);
    idle();
    #2 chk("full_held_off", 32'(mask_count), 32'd64);
    cyc(1'b1, pos_rand(), 1'b1, 9'h055, 1'b1, 1'b0);
    idle();
    #2 chk("full_pop_no_push", 32'(mask_count), 32'd63);
    cyc(1'b1, pos_rand(), 1'b0, '0, 1'b1, 1'b0);
    idle();
    #2 chk("full_refill", 32'(mask_count), 32'd64);
    drain();

    // Empty stall, then push-to-pop latency
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, 1'b1, 9'h044, 1'b1, 1'b0);
      #2 chk("stall_grad_ready", 32'(grad_ready), 32'd0);
    end
    cyc(1'b1, 9'h003, 1'b1, 9'h044, 1'b1, 1'b0);
    #2 chk("push_same_cycle", 32'(grad_ready), 32'd0);
    cyc(1'b0, '0, 1'b1, 9'h044, 1'b1, 1'b0);
    #2 chk("push_next_cycle", 32'(grad_ready), 32'd1);
    idle();
    idle();

    // Simultaneous push and pop at count 10
    for (int i = 0; i < 10; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, '0, 1'b1, 1'b0);
    idle();
    #2 chk("cnt10", 32'(mask_count), 32'd10);
    cyc(1'b1, pos_rand(), 1'b1, DATA_W'($urandom), 1'b1, 1'b0);
    idle();
    #2 chk("cnt10_pushpop", 32'(mask_count), 32'd10);
    drain();

    // Backpressure
    for (int i = 0; i < 4; i++) cyc(1'b1, pos_rand(), 1'b0, '0, 1'b1, 1'b0);
    idle();
    obs.delete();
    cyc(1'b0, '0, 1'b1, 9'h07F, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1, 9'h011, 1'b0, 1'b0);
      #2;
      chk("bp_out", 32'(grad_out), 32'h07F);
      chk("bp_grad_ready", 32'(grad_ready), 32'd0);
      chk("bp_count", 32'(mask_count), 32'd3);
    end
    cyc(1'b0, '0, 1'b1, 9'h011, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 9'h022, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 9'h033, 1'b1, 1'b0);
    repeat (3) idle();
    chk("bp_n", 32'(obs.size()), 32'd4);
    if (obs.size() == 4) begin
      chk("bp_0", 32'(obs[0]), 32'h07F);
      chk("bp_1", 32'(obs[1]), 32'h011);
      chk("bp_2", 32'(obs[2]), 32'h022);
      chk("bp_3", 32'(obs[3]), 32'h033);
    end

    // Flush with count 20 and an output pending
    for (int i = 0; i < 21; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 9'h066, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    chk("pre_flush_count", 32'(mask_count), 32'd20);
    chk("pre_flush_vld", 32'(grad_out_valid), 32'd1);
    cyc(1'b1, pos_rand(), 1'b1, 9'h077, 1'b0, 1'b1);
    idle();
    #2;
    chk("flush_count", 32'(mask_count), 32'd0);
    chk("flush_vld", 32'(grad_out_valid), 32'd0);

    // Asynchronous reset during streaming
    for (int i = 0; i < 5; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      cyc(1'b1, DATA_W'($urandom), 1'b1, DATA_W'($urandom), 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst_vld", 32'(grad_out_valid), 32'd0);
    chk("arst_count", 32'(mask_count), 32'd0);
    chk("arst_grad_out", 32'(grad_out), 32'd0);
    chk("arst_fwd_ready", 32'(fwd_ready), 32'd1);
    chk("arst_grad_ready", 32'(grad_ready), 32'd0);
    idle();
    idle();
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Randomised traffic with wrap-around
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 3) != 0), DATA_W'($urandom),
          1'($urandom_range(0, 2) != 0), DATA_W'($urandom),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 59) == 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_backward.md
# relu_backward

Backward-pass companion to the 9-bit forward ReLU stage of the CNN datapath. During the forward pass it records one mask bit per activation: 1 if the activation passed the ReLU, 0 if it was zeroed. During the backward pass it consumes those bits in the same order and gates the incoming gradient stream, producing dL/dx from dL/dy. It sits between the forward activation tap and the gradient path feeding the previous layer.

## Interface
Parameters:
- DATA_W, 9, activation and gradient width, two's complement
- DEPTH, 64, mask FIFO depth in entries; power of two, at least 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of the mask FIFO and the output register
- fwd_valid  in  1  forward activation present on fwd_in
- fwd_ready  out  1  mask FIFO can accept an entry
- fwd_in  in  DATA_W  forward-pass ReLU input activation
- grad_valid  in  1  gradient present on grad_in
- grad_ready  out  1  gradient accepted this cycle
- grad_in  in  DATA_W  upstream gradient dL/dy
- grad_out_valid  out  1  grad_out holds a result
- grad_out_ready  in  1  downstream accepts grad_out
- grad_out  out  DATA_W  gated gradient dL/dx
- mask_count  out  $clog2(DEPTH)+1  number of stored mask bits

## Operation
- Mask rule: mask = ~fwd_in[DATA_W-1]. Zero activations pass, consistent with the forward block, which passes an input of 0.
- Forward push occurs when fwd_valid && fwd_ready.
  - fwd_ready = (mask_count != DEPTH).
  - A full FIFO does not accept an entry even if a pop occurs in the same cycle.
- Backward pop occurs when grad_valid && grad_ready.
  - grad_ready = (mask_count != 0) && (!grad_out_valid || grad_out_ready).
  - The popped mask selects the result: grad_out <= mask ? grad_in : 0.
- Output register:
  - Loaded on a pop.
  - When there is no pop and grad_out_ready is 1, grad_out_valid clears.
  - grad_out holds its value while grad_out_valid && !grad_out_ready.
- Simultaneous push and pop: mask_count is unchanged, and both pointers advance.
- Pointers wrap modulo DEPTH. mask_count is the single source of truth for full and empty.
- A gradient arriving while the FIFO is empty stalls (grad_ready = 0). It is not an error and nothing is dropped.
- flush:
  - Clears the pointers, mask_count and grad_out_valid on the next edge.
  - Takes priority over a push or pop in the same cycle.
  - An output beat that is in flight is discarded.
- Reset values:
  - grad_out_valid = 0, grad_out = 0, mask_count = 0.
  - Pointers = 0, so fwd_ready = 1 and grad_ready = 0.
  - Mask storage contents are don't-care.
- Reset mid-operation clears everything immediately and asynchronously. The handshake outputs are valid again after the first edge following deassertion.

## Timing
- Latency: 1 cycle from grad accept to grad_out_valid.
- Throughput: 1 gradient per cycle when downstream is always ready.
- fwd_ready, grad_ready and mask_count are derived from registered state only. grad_ready also depends combinationally on grad_out_ready.
- A mask pushed in cycle N is poppable in cycle N+1, never in the same cycle.
- Sign arithmetic: no width change and no saturation. grad_out is bit-exact to either grad_in or 0.

## Structure
- Shared package relu_pkg holds:
  - DATA_W
  - a grad_t typedef (logic signed [DATA_W-1:0])
  - the default DEPTH constant
- Sub-module mask_fifo: a 1-bit-wide synchronous FIFO with push, pop, flush, count, full and empty. relu_backward instantiates it and adds the gating mux and the output register.

## Test plan
- Reset and ordering:
  - Hold rst, then release → fwd_ready=1, grad_ready=0, grad_out_valid=0, mask_count=0.
  - Push fwd_in = 9'h005, 9'h1FB (−5), 9'h000, then send grad_in = 9'h010, 9'h020, 9'h030 with grad_out_ready=1 → grad_out = 9'h010, 9'h000, 9'h030, each one cycle after accept.
- Full: push 64 positive activations → mask_count=64 and fwd_ready=0. A 65th push is held off. One pop followed by one push → count returns to 64.
- Empty stall and simultaneous push/pop:
  - grad_valid=1 with an empty FIFO for 5 cycles → grad_ready=0 throughout.
  - A push in cycle N → the gradient is accepted in cycle N+1.
  - Push and pop in the same cycle at count 10 → count stays 10.
- Backpressure: hold grad_out_ready=0 with grad_out=9'h07F valid → grad_out stays 9'h07F, grad_ready=0 and no pops occur. Release → stream resumes in order with no loss or duplication.
- Flush and async reset:
  - Assert flush with count 20 and an output pending → next cycle count=0 and grad_out_valid=0.
  - Assert rst asynchronously between edges during streaming → outputs clear immediately.
- Wrap-around: 200 random push/pop cycles against a scoreboard queue model → all outputs match, pointers wrap correctly, no overflow or underflow.
